// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between mem_stage (master) and data memory (slave).
interface mem_stage_if;
  logic        DReq;
  logic        DWe;
  logic [31:0] DAddr;
  logic [31:0] DWData;
  logic [31:0] DRData;
  logic        DAck;

  modport master (
    output DReq, DWe, DAddr, DWData,
    input  DRData, DAck
  );

  modport slave (
    input  DReq, DWe, DAddr, DWData,
    output DRData, DAck
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: passes ALU results through, runs LW/SW on a req/ack bus with a watchdog.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHK_EN.
module mem_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               ExValid,
  input  logic [5:0]         OpCode,
  input  logic [31:0]        ALUOut,
  input  logic [31:0]        StoreData,
  input  logic [4:0]         WrReg,
  input  logic               RegWrite,
  output logic               MemStall,
  mem_stage_if.master        dmem,
  output logic               WbValid,
  output logic [31:0]        WbData,
  output logic [4:0]         WbReg,
  output logic               WbRegWrite,
  output logic               BusErr,
  output logic               AddrErr
);

  localparam logic [5:0] OpLw     = 6'h23;
  localparam logic [5:0] OpSw     = 6'h2B;
  localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

  typedef enum logic [0:0] {StIdle, StWait} stateT;

  stateT       state;
  logic [7:0]  waitCnt;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddr;
  logic [31:0] dWData;
  logic [4:0]  pendReg;
  logic        isMem;
  logic        misaligned;

  assign isMem = (OpCode == OpLw) || (OpCode == OpSw);

`ifdef MEM_ALIGN_CHK_EN
  assign misaligned = (ALUOut[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign MemStall    = (state == StWait);
  assign dmem.DReq   = dReq;
  assign dmem.DWe    = dWe;
  assign dmem.DAddr  = dAddr;
  assign dmem.DWData = dWData;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= StIdle;
      waitCnt    <= 8'd0;
      dReq       <= 1'b0;
      dWe        <= 1'b0;
      dAddr      <= 32'd0;
      dWData     <= 32'd0;
      pendReg    <= 5'd0;
      WbValid    <= 1'b0;
      WbData     <= 32'd0;
      WbReg      <= 5'd0;
      WbRegWrite <= 1'b0;
      BusErr     <= 1'b0;
      AddrErr    <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses; Wb data fields hold.
      WbValid <= 1'b0;
      BusErr  <= 1'b0;
      AddrErr <= 1'b0;
      unique case (state)
        StIdle: begin
          if (ExValid) begin
            if (!isMem) begin
              WbValid    <= 1'b1;
              WbData     <= ALUOut;
              WbReg      <= WrReg;
              WbRegWrite <= RegWrite;
            end else if (misaligned) begin
              WbValid    <= 1'b1;
              AddrErr    <= 1'b1;
              WbData     <= ALUOut;
              WbReg      <= WrReg;
              WbRegWrite <= 1'b0;
            end else begin
              state   <= StWait;
              waitCnt <= 8'd0;
              dReq    <= 1'b1;
              dWe     <= (OpCode == OpSw);
              dAddr   <= {ALUOut[31:2], 2'b00};
              dWData  <= StoreData;
              pendReg <= WrReg;
            end
          end
        end
        StWait: begin
          // An acknowledge in the abort cycle takes priority over the watchdog.
          if (dmem.DAck) begin
            state      <= StIdle;
            dReq       <= 1'b0;
            WbValid    <= 1'b1;
            WbReg      <= pendReg;
            WbRegWrite <= !dWe;
            WbData     <= dWe ? dAddr : dmem.DRData;
          end else if (waitCnt == WaitLast) begin
            state      <= StIdle;
            dReq       <= 1'b0;
            WbValid    <= 1'b1;
            BusErr     <= 1'b1;
            WbReg      <= pendReg;
            WbRegWrite <= 1'b0;
            WbData     <= 32'd0;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule
